// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter with a TX FIFO on a data-memory store/load port
// Ports: clk; rst (async, active-low); sel/wen/address/wdata/byte_mask store-load interface;
// rdata combinational load data; tx serial line (idle high); irq level interrupt.
module uart_tx_mmio #(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        wen,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  input  logic [2:0]  byte_mask,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_C = FIFO_DEPTH[AW:0];
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        state_q;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic [15:0]   div_q, div_d, baud_q, wmask;
  logic [7:0]    shift_q, cnt8;
  logic [2:0]    bit_q;
  logic [1:0]    reg_sel;
  logic [31:0]   raw, status;
  logic          tx_en_q, irq_en_q, ovf_q, ovf_d, tx_q, irq_q;
  logic          we, push, push_ok, pop, full, empty, busy;
  logic          unused_ok;
  assign unused_ok = ^{address[31:4], address[1:0], wdata[31:16]};
  assign reg_sel = address[3:2];
  assign cnt8 = 8'(cnt_q);
  always_comb begin
    we      = sel && wen;
    wmask   = byte_mask[1:0] == 2'b00 ? 16'h00FF : byte_mask[1:0] == 2'b01 ? 16'hFFFF : 16'hFFFF;
    full    = cnt_q == FULL_C;
    empty   = cnt_q == '0;
    busy    = state_q != IDLE || !empty;
    push    = we && reg_sel == 2'd0;
    push_ok = push && !full;
    pop     = tx_en_q && !empty && (state_q == IDLE || (state_q == STOP && baud_q == '0));
    cnt_d   = cnt_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
    div_d   = we && reg_sel == 2'd2 ? (div_q & ~wmask) | (wdata[15:0] & wmask) : div_q;
    ovf_d   = (push && full) || (ovf_q && !(we && reg_sel == 2'd1 && wdata[3]));
  end
  always_ff @(posedge clk)
    if (push_ok) mem[wptr_q] <= wdata[7:0];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      div_q    <= DEFAULT_DIV;
      baud_q   <= '0;
      shift_q  <= '0;
      bit_q    <= '0;
      tx_en_q  <= 1'b1;
      irq_en_q <= 1'b0;
      ovf_q    <= 1'b0;
      tx_q     <= 1'b1;
      irq_q    <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      ovf_q  <= ovf_d;
      irq_q  <= irq_en_q && empty && state_q == IDLE;
      wptr_q <= push_ok ? wptr_q + AW'(1) : wptr_q;
      if (we && reg_sel == 2'd3) {irq_en_q, tx_en_q} <= wdata[1:0];
      if (pop) begin
        shift_q <= mem[rptr_q];
        rptr_q  <= rptr_q + AW'(1);
        baud_q  <= div_q;
        tx_q    <= 1'b0;
        state_q <= START;
      end else if (state_q != IDLE) begin
        if (baud_q != '0) baud_q <= baud_q - 16'd1;
        else begin
          baud_q <= div_q;
          case (state_q)
            START: begin
              tx_q    <= shift_q[0];
              bit_q   <= '0;
              state_q <= DATA;
            end
            DATA: begin
              if (bit_q == 3'd7) begin
                tx_q    <= 1'b1;
                state_q <= STOP;
              end else begin
                shift_q <= shift_q >> 1;
                tx_q    <= shift_q[1];
                bit_q   <= bit_q + 3'd1;
              end
            end
            default: state_q <= IDLE;
          endcase
        end
      end
    end
  end
  assign status = {20'b0, cnt8, ovf_q, empty, full, busy};
  always_comb begin
    raw   = reg_sel == 2'd1 ? status : reg_sel == 2'd2 ? {16'b0, div_q} :
            reg_sel == 2'd3 ? {30'b0, irq_en_q, tx_en_q} : '0;
    rdata = !sel ? '0 :
            byte_mask == 3'b000 ? {{24{raw[7]}}, raw[7:0]} :
            byte_mask == 3'b001 ? {{16{raw[15]}}, raw[15:0]} :
            byte_mask == 3'b100 ? {24'b0, raw[7:0]} :
            byte_mask == 3'b101 ? {16'b0, raw[15:0]} : raw;
  end
  assign tx  = tx_q;
  assign irq = irq_q;
endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: directed self-checking bench for uart_tx_mmio
module tb_uart_tx_mmio;
  logic        clk = 1'b0, rst = 1'b0, sel = 1'b0, wen = 1'b0;
  logic [31:0] address = '0, wdata = '0;
  logic [2:0]  byte_mask = 3'b010;
  logic [31:0] rdata;
  logic        tx, irq;
  int          total = 0, bad = 0;
  logic [9:0]  fr;
  uart_tx_mmio #(.FIFO_DEPTH(8), .DEFAULT_DIV(16'd867)) dut (
    .clk(clk), .rst(rst), .sel(sel), .wen(wen), .address(address), .wdata(wdata),
    .byte_mask(byte_mask), .rdata(rdata), .tx(tx), .irq(irq)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [2:0] bm);
    sel = 1'b1; wen = 1'b1; address = {28'h0, a}; wdata = d; byte_mask = bm;
    @(posedge clk);
    @(negedge clk);
    sel = 1'b0; wen = 1'b0; byte_mask = 3'b010;
  endtask
  task automatic rd(input logic [3:0] a, input logic [2:0] bm, input string tag, input logic [31:0] exp);
    sel = 1'b1; wen = 1'b0; address = {28'h0, a}; byte_mask = bm;
    #1;
    chk(tag, rdata, exp);
    sel = 1'b0; byte_mask = 3'b010;
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    cyc(3);
    chk("rst_hold_tx", {31'b0, tx}, 32'd1);
    rst = 1'b1;
    cyc(1);
    rd(4'h4, 3'b010, "rst_status", 32'h4);
    rd(4'h8, 3'b010, "rst_div", 32'd867);
    rd(4'hC, 3'b010, "rst_ctrl", 32'd1);
    chk("rst_tx", {31'b0, tx}, 32'd1);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    rd(4'h4, 3'b010, "nosel_rdata", 32'h4);
    wr(4'h8, 32'd3, 3'b010);
    wr(4'h0, 32'hA5, 3'b000);
    chk("pre_start_tx", {31'b0, tx}, 32'd1);
    fr = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("frame_a5", {31'b0, tx}, {31'b0, fr[i/4]});
    end
    rd(4'h4, 3'b010, "busy_in_stop", 32'h5);
    cyc(1);
    rd(4'h4, 3'b010, "idle_after_frame", 32'h4);
    wr(4'hC, 32'd0, 3'b010);
    for (int j = 0; j < 9; j++) wr(4'h0, j, 3'b000);
    rd(4'h4, 3'b010, "full_ovf_status", 32'h8B);
    wr(4'hC, 32'd1, 3'b010);
    for (int j = 0; j < 8; j++) begin
      fr = {1'b1, 8'(j), 1'b0};
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        chk("b2b_frame", {31'b0, tx}, {31'b0, fr[i/4]});
      end
    end
    @(negedge clk);
    chk("b2b_idle_tx", {31'b0, tx}, 32'd1);
    rd(4'h4, 3'b010, "drained_ovf", 32'hC);
    wr(4'h4, 32'h8, 3'b010);
    rd(4'h4, 3'b010, "ovf_cleared", 32'h4);
    wr(4'h8, 32'h0000_80F0, 3'b010);
    rd(4'h8, 3'b000, "lb", 32'hFFFF_FFF0);
    rd(4'h8, 3'b100, "lbu", 32'h0000_00F0);
    rd(4'h8, 3'b001, "lh", 32'hFFFF_80F0);
    rd(4'h8, 3'b101, "lhu", 32'h0000_80F0);
    rd(4'hB, 3'b110, "lw_undef_lowbits", 32'h0000_80F0);
    rd(4'h0, 3'b010, "txdata_reads0", 32'h0);
    wr(4'h8, 32'hFFFF_FF12, 3'b000);
    rd(4'h8, 3'b010, "sb_div", 32'h0000_8012);
    wr(4'h8, 32'd3, 3'b010);
    wr(4'hC, 32'd0, 3'b010);
    for (int j = 0; j < 4; j++) wr(4'h0, 32'h0, 3'b000);
    wr(4'hC, 32'd1, 3'b010);
    cyc(40);
    chk("pp_stop_tx", {31'b0, tx}, 32'd1);
    rd(4'h4, 3'b010, "pp_before", 32'h31);
    wr(4'h0, 32'h0, 3'b000);
    rd(4'h4, 3'b010, "pp_after", 32'h31);
    chk("pp_start_tx", {31'b0, tx}, 32'd0);
    cyc(8);
    chk("mid_data_tx", {31'b0, tx}, 32'd0);
    rst = 1'b0;
    #1;
    chk("async_rst_tx", {31'b0, tx}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    rd(4'h4, 3'b010, "post_rst_status", 32'h4);
    rd(4'h8, 3'b010, "post_rst_div", 32'd867);
    wr(4'hC, 32'd3, 3'b010);
    chk("irq_not_yet", {31'b0, irq}, 32'd0);
    @(negedge clk);
    chk("irq_set", {31'b0, irq}, 32'd1);
    wr(4'h0, 32'h55, 3'b000);
    chk("irq_lag", {31'b0, irq}, 32'd1);
    @(negedge clk);
    chk("irq_clear", {31'b0, irq}, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
- Memory-mapped UART transmitter; the responder end of the core's data-memory store/load interface (sel, wen, address, wdata, byte_mask, rdata).
- Software stores bytes into TXDATA. They queue in an internal FIFO and are serialised 8N1 on `tx`.
- Sits beside the data memory. An external address decoder asserts `sel` for this block's 16-byte window.
- Reads are combinational, so single-cycle loads complete in the same cycle. Writes take effect on the rising clock edge.

Parameters:
- FIFO_DEPTH, 8, TX FIFO entries; power of two, 2..128.
- DEFAULT_DIV, 867, reset value of BAUDDIV; bit period = BAUDDIV+1 clocks.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- sel  input  1  window select from address decoder.
- wen  input  1  store strobe; write occurs when sel&&wen at rising edge.
- address  input  32  byte address; only [3:2] decoded, [1:0] ignored.
- wdata  input  32  store data.
- byte_mask  input  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- rdata  output  32  combinational load data; 0 when !sel.
- tx  output  1  serial out, idle high, registered.
- irq  output  1  level: CTRL.irq_en && FIFO empty && FSM IDLE; registered.

Behaviour:
- Register map (address[3:2]):
  - 0 TXDATA: write pushes wdata[7:0]; reads 0.
  - 1 STATUS (read-only except bit3):
    - [0] busy = FSM!=IDLE || count!=0
    - [1] full
    - [2] empty
    - [3] ovf, sticky; write 1 to clear
    - [11:4] count
    - other bits 0
  - 2 BAUDDIV: [15:0]; upper bits read 0.
  - 3 CTRL: [0] tx_en, [1] irq_en.
- Store width:
  - SB writes reg bits [7:0]; SH writes [15:0]; SW writes all implemented bits. Unwritten bits hold.
  - Any width to TXDATA pushes one byte.
  - Codes 100/101 on a store are treated as SB/SH.
- Load extension:
  - 000 sign-extend [7:0]; 001 sign-extend [15:0]; 100/101 zero-extend; 010 full word.
  - Undefined codes (011, 11x) return full word.
- Reset (rst low, async):
  - tx=1, irq=0, FSM IDLE, FIFO empty, count=0, ovf=0.
  - BAUDDIV=DEFAULT_DIV, CTRL=2'b01.
  - Reset mid-frame aborts the frame immediately; tx goes high.
- FIFO push/pop:
  - Push when full (evaluated before the edge) is dropped and sets ovf. This holds even if a pop occurs in the same cycle.
  - Simultaneous accepted push and pop leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH. Count width is log2(FIFO_DEPTH)+1.
- FSM states IDLE, START, DATA, STOP; bit counter 0..7; baud counter 16-bit.
  - IDLE: if tx_en && count!=0, pop head into shift register, load baud counter with BAUDDIV, tx<=0, go to START.
  - A byte stored at edge N drives tx low after edge N+1.
  - Each state lasts BAUDDIV+1 clocks. The baud counter decrements and at 0 reloads from the current BAUDDIV.
  - A BAUDDIV change therefore takes effect at the next bit boundary.
  - START→DATA: tx<=shift[0] (LSB first).
  - DATA: on each bit boundary shift right. After bit 7 go to STOP with tx<=1.
  - STOP end: if tx_en && count!=0, pop and go directly to START (back-to-back, no idle gap); else go to IDLE.
- tx_en cleared mid-frame: current frame completes, no further pops, FIFO retained.
- BAUDDIV=0 gives 1 clock per bit.
- irq updates one cycle after the condition changes.

Test Plan:
- Reset values: hold rst low, release; read STATUS → 0x00000004, BAUDDIV → 867, CTRL → 1. tx=1, irq=0.
- Single frame: SW BAUDDIV=3, SB TXDATA=0xA5.
  - tx=0 for 4 clocks starting 1 cycle after the store edge.
  - Then bits 1,0,1,0,0,1,0,1, 4 clocks each; stop=1 for 4 clocks.
  - busy clears after 40 clocks.
- Back-to-back and overflow: tx_en=0, push 9 bytes 0x00..0x08.
  - STATUS reads full=1, count=8, ovf=1.
  - Set tx_en=1: exactly bytes 0x00..0x07 are sent with no idle gap between stop and start.
  - Write STATUS bit3=1 → ovf=0.
- Load extension: BAUDDIV=0x0000_80F0.
  - LB → 0xFFFF_FFF0; LBU → 0x0000_00F0; LH → 0xFFFF_80F0; LHU → 0x0000_80F0.
  - SB 0x12 to BAUDDIV → reads 0x0000_8012.
- Simultaneous push/pop: FIFO count=3, frame ending. Push on the same edge as the STOP→START pop → count stays 3, no ovf.
- Reset mid-frame and irq:
  - Assert rst during DATA → tx=1 immediately (without a clock edge); STATUS=0x4 after release.
  - Set CTRL=3 with FIFO empty and FSM idle → irq=1 one cycle later.
  - Push a byte → irq=0.
